// File: rtl/rk_tape_player.sv
// rk_tape_player: serialises a byte stream into a biphase tape waveform.
// The stream is a leader of 0x00 bytes, then a sync byte, then the data
// bytes fetched from the source. Each bit is sent MSB first as two
// half-cells: the first at ~bit and the second at bit. All waveform timing
// counts ce strobes.
module rk_tape_player #(
  parameter int         HALF_DIV   = 600,
  parameter int         LEAD_BYTES = 256,
  parameter logic [7:0] SYNC_BYTE  = 8'hE6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       tape_out
);

  localparam int HW = $clog2(HALF_DIV);
  localparam int LW = (LEAD_BYTES > 1) ? $clog2(LEAD_BYTES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
  localparam logic [LW-1:0] LEAD_LAST = LW'((LEAD_BYTES > 0) ? LEAD_BYTES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_SYNC,
    ST_FETCH,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic          phase;
  logic [2:0]    bit_idx;
  logic [LW-1:0] lead_cnt;
  logic [7:0]    shift;
  logic          last_flag;

  // Playback sequencer: state, cell timing counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      half_cnt   <= '0;
      phase      <= 1'b0;
      bit_idx    <= 3'd0;
      lead_cnt   <= '0;
      shift      <= 8'h00;
      last_flag  <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tape_out   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tape_out   <= 1'b0;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            half_cnt <= '0;
            phase    <= 1'b0;
            bit_idx  <= 3'd7;
            lead_cnt <= '0;
            if (LEAD_BYTES == 0) begin
              state    <= ST_SYNC;
              shift    <= SYNC_BYTE;
              tape_out <= ~SYNC_BYTE[7];
            end else begin
              // First half-cell of a 0x00 leader byte is ~0 = 1.
              state    <= ST_LEADER;
              shift    <= 8'h00;
              tape_out <= 1'b1;
            end
          end
        end

        ST_LEADER, ST_SYNC, ST_DATA: begin
          if (ce) begin
            if (half_cnt != HALF_LAST) begin
              half_cnt <= half_cnt + 1'b1;
            end else begin
              half_cnt <= '0;
              if (!phase) begin
                // Mid-cell transition: second half carries the bit itself.
                phase    <= 1'b1;
                tape_out <= shift[bit_idx];
              end else begin
                phase <= 1'b0;
                if (bit_idx != 3'd0) begin
                  bit_idx  <= bit_idx - 3'd1;
                  tape_out <= ~shift[bit_idx - 3'd1];
                end else begin
                  // End of a byte: pick what comes next.
                  bit_idx <= 3'd7;
                  if (state == ST_LEADER) begin
                    if (lead_cnt == LEAD_LAST) begin
                      state    <= ST_SYNC;
                      shift    <= SYNC_BYTE;
                      tape_out <= ~SYNC_BYTE[7];
                    end else begin
                      lead_cnt <= lead_cnt + 1'b1;
                      tape_out <= 1'b1;
                    end
                  end else if (state == ST_DATA && last_flag) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                  end else begin
                    // Level is held while waiting for the source.
                    state      <= ST_FETCH;
                    byte_ready <= 1'b1;
                  end
                end
              end
            end
          end
        end

        ST_FETCH: begin
          if (byte_valid) begin
            state      <= ST_DATA;
            shift      <= byte_data;
            last_flag  <= byte_last;
            byte_ready <= 1'b0;
            tape_out   <= ~byte_data[7];
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          tape_out <= 1'b0;
        end

        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
          tape_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule
